// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums N_TERMS signed 8-bit products per result, with valid/ready on both sides
module booth_product_accumulator #(
  parameter int N_TERMS  = 4,
  parameter int ACC_W    = 12,
  parameter int CNT_W    = 3,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] term_cnt
);
  typedef enum logic {ACCUM, DONE} state_t;
  localparam logic [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  state_t state, state_nx;
  logic live;
  logic [ACC_W-1:0] acc, clipped;
  logic [ACC_W:0] sum;
  logic ovf_acc, step_ovf, accept, last;
  assign sum      = {acc[ACC_W-1], acc} + {{(ACC_W-7){prod[7]}}, prod};
  assign step_ovf = sum[ACC_W] ^ sum[ACC_W-1];
  assign clipped  = (step_ovf && SATURATE != 0) ? (sum[ACC_W] ? MIN_V : MAX_V) : sum[ACC_W-1:0];
  assign last     = term_cnt == CNT_W'(N_TERMS - 1);
  assign accept   = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ACCUM;
    else state <= state_nx;
  always_comb
    state_nx = clear ? ACCUM :
               (state == ACCUM && accept && last) ? DONE :
               (state == DONE && out_ready) ? ACCUM : state;
  // live holds in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = state == ACCUM && live && !clear;
    out_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      live     <= 1'b0;
      acc      <= '0;
      term_cnt <= '0;
      ovf_acc  <= 1'b0;
      result   <= '0;
      ovf      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (clear) begin
        acc      <= '0;
        term_cnt <= '0;
        ovf_acc  <= 1'b0;
      end else if (accept && last) begin
        result   <= clipped;
        ovf      <= ovf_acc | step_ovf;
        acc      <= '0;
        term_cnt <= '0;
        ovf_acc  <= 1'b0;
      end else if (accept) begin
        acc      <= clipped;
        term_cnt <= term_cnt + 1'b1;
        ovf_acc  <= ovf_acc | step_ovf;
      end
    end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: table vectors plus corner sequences across four parameterisations
module tb_booth_product_accumulator;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic clear [4], in_valid [4], out_ready [4];
  logic [7:0] prod [4];
  logic in_ready [4], out_valid [4], ovf [4];
  logic [2:0] term_cnt [4];
  logic [11:0] r0, r3;
  logic [7:0] r1, r2;
  booth_product_accumulator u0 (.clk(clk), .rst_n(rst_n), .clear(clear[0]), .prod(prod[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .result(r0), .ovf(ovf[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .term_cnt(term_cnt[0]));
  booth_product_accumulator #(.ACC_W(8), .SATURATE(1)) u1 (.clk(clk), .rst_n(rst_n), .clear(clear[1]), .prod(prod[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .result(r1), .ovf(ovf[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .term_cnt(term_cnt[1]));
  booth_product_accumulator #(.ACC_W(8), .SATURATE(0)) u2 (.clk(clk), .rst_n(rst_n), .clear(clear[2]), .prod(prod[2]),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .result(r2), .ovf(ovf[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .term_cnt(term_cnt[2]));
  booth_product_accumulator #(.N_TERMS(1)) u3 (.clk(clk), .rst_n(rst_n), .clear(clear[3]), .prod(prod[3]),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]), .result(r3), .ovf(ovf[3]), .out_valid(out_valid[3]),
    .out_ready(out_ready[3]), .term_cnt(term_cnt[3]));
  typedef struct { int inst; int nt; logic [31:0] p; int res; int ovf; int hold; } vec_t;
  typedef struct { int inst; int res; int ovf; } exp_t;
  vec_t vecs [8];
  exp_t sb [$];
  int n_cmp = 0, n_err = 0;
  function automatic vec_t mk(int inst, int nt, int a, int b, int c, int d, int res, int ovf, int hold);
    vec_t v;
    v.inst = inst; v.nt = nt; v.p = {8'(d), 8'(c), 8'(b), 8'(a)}; v.res = res; v.ovf = ovf; v.hold = hold;
    return v;
  endfunction
  function automatic int res(int i);
    case (i)
      0: res = $signed(r0);
      1: res = $signed(r1);
      2: res = $signed(r2);
      default: res = $signed(r3);
    endcase
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // called just after a falling edge; returns just after the falling edge that follows the accepting edge
  task automatic put(int i, int p);
    int t = 0;
    prod[i] = 8'(p);
    in_valid[i] = 1'b1;
    #1;
    while (!in_ready[i] && t < 20) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (t >= 20) chk("put_timeout", 0, 1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    #1;
  endtask
  task automatic collect(int i, int hold);
    exp_t e;
    chk("latency_out_valid", int'(out_valid[i]), 1);
    chk("done_in_ready", int'(in_ready[i]), 0);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("sb_inst", i, e.inst);
    chk("result", res(i), e.res);
    chk("ovf", int'(ovf[i]), e.ovf);
    for (int h = 0; h < hold; h++) begin
      in_valid[i] = 1'b1;
      @(negedge clk);
      #1;
      chk("hold_result", res(i), e.res);
      chk("hold_in_ready", int'(in_ready[i]), 0);
      chk("hold_out_valid", int'(out_valid[i]), 1);
    end
    in_valid[i] = 1'b0;
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    #1;
    chk("hs_out_valid", int'(out_valid[i]), 0);
    chk("hs_in_ready", int'(in_ready[i]), 1);
  endtask
  task automatic run(int i, int a, int b, int c, int d, int r);
    put(i, a); put(i, b); put(i, c); put(i, d);
    sb.push_back('{i, r, 0});
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      clear[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0; prod[i] = 8'd0;
    end
    vecs[0] = mk(0, 4, 12, -6, 49, 64, 119, 0, 5);
    vecs[1] = mk(1, 4, 64, 64, 64, -8, 119, 1, 0);
    vecs[2] = mk(1, 4, -64, -64, -64, -64, -128, 1, 0);
    vecs[3] = mk(1, 4, 1, 1, 1, 1, 4, 0, 0);
    vecs[4] = mk(2, 4, 64, 64, 0, 0, -128, 1, 0);
    vecs[5] = mk(3, 1, -64, 0, 0, 0, -64, 0, 0);
    vecs[6] = mk(0, 4, -128, -128, -128, -128, -512, 0, 0);
    vecs[7] = mk(0, 4, 127, 127, 127, 127, 508, 0, 1);
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rst_in_ready", int'(in_ready[i]), 0);
      chk("rst_out_valid", int'(out_valid[i]), 0);
      chk("rst_result", res(i), 0);
      chk("rst_term_cnt", int'(term_cnt[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("post_rst_in_ready", int'(in_ready[i]), 1);
    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].nt; k++) begin
        put(vecs[v].inst, int'($signed(vecs[v].p[8*k +: 8])));
        chk("term_cnt", int'(term_cnt[vecs[v].inst]), (k + 1) % vecs[v].nt);
      end
      sb.push_back('{vecs[v].inst, vecs[v].res, vecs[v].ovf});
      collect(vecs[v].inst, vecs[v].hold);
    end
    put(0, 10); put(0, 10);
    chk("clr_pre_cnt", int'(term_cnt[0]), 2);
    clear[0] = 1'b1; in_valid[0] = 1'b1; prod[0] = 8'd10;
    #1;
    chk("clr_in_ready", int'(in_ready[0]), 0);
    @(negedge clk);
    #1;
    chk("clr_term_cnt", int'(term_cnt[0]), 0);
    clear[0] = 1'b0; in_valid[0] = 1'b0;
    run(0, 1, 2, 3, 4, 10);
    collect(0, 0);
    run(0, 5, 5, 5, 5, 20);
    chk("clr_done_valid", int'(out_valid[0]), 1);
    clear[0] = 1'b1; out_ready[0] = 1'b1;
    @(negedge clk);
    clear[0] = 1'b0; out_ready[0] = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("clr_done_out_valid", int'(out_valid[0]), 0);
    chk("clr_done_result_kept", res(0), 20);
    chk("clr_done_in_ready", int'(in_ready[0]), 1);
    put(1, 1); put(1, 1); put(1, 1);
    run(0, 7, 7, 7, 7, 28);
    chk("pre_arst_valid", int'(out_valid[0]), 1);
    chk("pre_arst_cnt1", int'(term_cnt[1]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid[0]), 0);
    chk("arst_result", res(0), 0);
    chk("arst_term_cnt0", int'(term_cnt[0]), 0);
    chk("arst_term_cnt1", int'(term_cnt[1]), 0);
    chk("arst_in_ready", int'(in_ready[0]), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rearm_in_ready", int'(in_ready[0]), 1);
    run(0, 2, 2, 2, 2, 8);
    collect(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
